alu_operand_loader: RTL and testbench



---
 rtl/alu_operand_loader.sv | 102 ++++++++++
 tb/tb_alu_operand_loader.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_loader.sv
// alu_operand_loader: gathers A, B and opcode beats from an 8-bit bus and issues them as one operation.
// Latency: op_valid rises the cycle after the opcode beat is accepted; 4 cycles per op at full rate.
// Backpressure: in_ready drops while an op is pending; operands hold until op_ready is seen.
// Optional feature: define ALU_LOADER_KEEP_A_EN to add keep_a (retain operand A across ops).
module alu_operand_loader (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       flush,
   output logic [7:0] a_out,
   output logic [7:0] b_out,
   output logic [3:0] opcode_out,
   output logic       op_valid,
   input  logic       op_ready,
`ifdef ALU_LOADER_KEEP_A_EN
   input  logic       keep_a,
`endif
   output logic [7:0] op_count
);

   typedef enum logic [1:0] {
      LOAD_A  = 2'd0,
      LOAD_B  = 2'd1,
      LOAD_OP = 2'd2,
      ISSUE   = 2'd3
   } state_t;

   state_t state;

   // Handshake qualifier, used so flush can still let a same-cycle issue complete.
   logic issue_hs;
   assign issue_hs = op_valid && op_ready;

   // Single FSM: state, operand registers, op counter and registered handshake outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= LOAD_A;
         a_out      <= 8'h00;
         b_out      <= 8'h00;
         opcode_out <= 4'h0;
         op_count   <= 8'h00;
         in_ready   <= 1'b1;
         op_valid   <= 1'b0;
      end else if (flush) begin
         // Flush discards any partial or pending op, but a handshake in the
         // same cycle has already been seen by the ALU, so it still counts.
         if (issue_hs) begin
            op_count <= op_count + 8'd1;
         end
         state      <= LOAD_A;
         a_out      <= 8'h00;
         b_out      <= 8'h00;
         opcode_out <= 4'h0;
         in_ready   <= 1'b1;
         op_valid   <= 1'b0;
      end else begin
         case (state)
            LOAD_A: begin
               if (in_valid) begin
                  a_out <= in_data;
                  state <= LOAD_B;
               end
            end
            LOAD_B: begin
               if (in_valid) begin
                  b_out <= in_data;
                  state <= LOAD_OP;
               end
            end
            LOAD_OP: begin
               if (in_valid) begin
                  opcode_out <= in_data[3:0];
                  state      <= ISSUE;
                  in_ready   <= 1'b0;
                  op_valid   <= 1'b1;
               end
            end
            ISSUE: begin
               // Operands are left as-is on issue; they only change on the next load.
               if (op_ready) begin
                  op_count <= op_count + 8'd1;
                  in_ready <= 1'b1;
                  op_valid <= 1'b0;
`ifdef ALU_LOADER_KEEP_A_EN
                  state    <= keep_a ? LOAD_B : LOAD_A;
`else
                  state    <= LOAD_A;
`endif
               end
            end
            default: begin
               state    <= LOAD_A;
               in_ready <= 1'b1;
               op_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_operand_loader.sv
// tb_alu_operand_loader: directed test-plan steps followed by random traffic.
// Reference: a queue of accepted beats; an op is pending when three beats are held.
// Every step compares all DUT outputs with the reference one time unit after the clock edge.
module tb_alu_operand_loader;

   logic       clk;
   logic       rst;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       flush;
   logic [7:0] a_out;
   logic [7:0] b_out;
   logic [3:0] opcode_out;
   logic       op_valid;
   logic       op_ready;
   logic       keep_a;
   logic [7:0] op_count;

   int checks   = 0;
   int failures = 0;

   // reference state
   logic [7:0] q[$];
   logic [7:0] exp_a, exp_b, exp_op;
   int         exp_cnt;

   alu_operand_loader dut (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .flush      (flush),
      .a_out      (a_out),
      .b_out      (b_out),
      .opcode_out (opcode_out),
      .op_valid   (op_valid),
      .op_ready   (op_ready),
`ifdef ALU_LOADER_KEEP_A_EN
      .keep_a     (keep_a),
`endif
      .op_count   (op_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference update for one clock edge, from the inputs currently driven.
   task automatic model_update();
      if (rst) begin
         q.delete();
         exp_a = 0; exp_b = 0; exp_op = 0; exp_cnt = 0;
      end else begin
         if (q.size() == 3 && op_ready) exp_cnt = (exp_cnt + 1) % 256;
         if (flush) begin
            q.delete();
            exp_a = 0; exp_b = 0; exp_op = 0;
         end else if (q.size() == 3) begin
            if (op_ready) begin
               q.delete();
`ifdef ALU_LOADER_KEEP_A_EN
               if (keep_a) q.push_back(exp_a);
`endif
            end
         end else if (in_valid) begin
            q.push_back(in_data);
            if (q.size() == 1) exp_a = in_data;
            else if (q.size() == 2) exp_b = in_data;
            else exp_op = {4'h0, in_data[3:0]};
         end
      end
   endtask

   task automatic check_all(input string tag);
      check_eq({tag, ".in_ready"}, {7'd0, in_ready}, {7'd0, (q.size() < 3)});
      check_eq({tag, ".op_valid"}, {7'd0, op_valid}, {7'd0, (q.size() == 3)});
      check_eq({tag, ".a_out"}, a_out, exp_a);
      check_eq({tag, ".b_out"}, b_out, exp_b);
      check_eq({tag, ".opcode_out"}, {4'h0, opcode_out}, exp_op);
      check_eq({tag, ".op_count"}, op_count, exp_cnt[7:0]);
   endtask

   task automatic step(input string tag, input logic v, input logic [7:0] d, input logic r,
                       input logic f, input logic k, input logic rs);
      in_valid = v; in_data = d; op_ready = r; flush = f; keep_a = k; rst = rs;
      model_update();
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; op_ready = 1'b0; flush = 1'b0; keep_a = 1'b0;
      q.delete(); exp_a = 0; exp_b = 0; exp_op = 0; exp_cnt = 0;

      // reset values
      step("reset0", 0, 8'h00, 0, 0, 0, 1);
      step("reset1", 0, 8'h00, 0, 0, 0, 1);
      check_eq("reset.in_ready_const", {7'd0, in_ready}, 8'h01);
      check_eq("reset.op_count_const", op_count, 8'h00);

      // basic load and issue
      step("basic.a", 1, 8'h12, 1, 0, 0, 0);
      step("basic.b", 1, 8'h34, 1, 0, 0, 0);
      in_valid = 1; in_data = 8'hA5; op_ready = 0; flush = 0; keep_a = 0; rst = 0;
      model_update();
      @(posedge clk); #1;
      check_all("basic.op");
      check_eq("basic.op_valid_const", {7'd0, op_valid}, 8'h01);
      check_eq("basic.a_const", a_out, 8'h12);
      check_eq("basic.b_const", b_out, 8'h34);
      check_eq("basic.opc_const", {4'h0, opcode_out}, 8'h05);
      step("basic.issue", 0, 8'h00, 1, 0, 0, 0);
      check_eq("basic.count_const", op_count, 8'h01);

      // backpressure: ready held low with an active input beat
      step("bp.a", 1, 8'h5A, 0, 0, 0, 0);
      step("bp.b", 1, 8'hC3, 0, 0, 0, 0);
      step("bp.op", 1, 8'h79, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) step("bp.hold", 1, 8'hFF, 0, 0, 0, 0);
      check_eq("bp.a_const", a_out, 8'h5A);
      step("bp.issue", 1, 8'hFF, 1, 0, 0, 0);
      check_eq("bp.count_const", op_count, 8'h02);

      // flush mid-load discards the concurrent beat
      step("fl.a", 1, 8'h11, 0, 0, 0, 0);
      step("fl.b", 1, 8'h22, 0, 0, 0, 0);
      step("fl.flush", 1, 8'h03, 0, 1, 0, 0);
      check_eq("fl.a_const", a_out, 8'h00);
      step("fl.idle", 0, 8'h00, 0, 0, 0, 0);

      // flush together with an issue handshake still counts the op
      step("flhs.a", 1, 8'h01, 0, 0, 0, 0);
      step("flhs.b", 1, 8'h02, 0, 0, 0, 0);
      step("flhs.op", 1, 8'h03, 0, 0, 0, 0);
      step("flhs.fl", 0, 8'h00, 1, 1, 1, 0);
      step("flhs.after", 0, 8'h00, 0, 0, 0, 0);

      // wrap-around: full-rate issue until the counter passes 0xFF
      while (exp_cnt != 255) step("wrap.run", 1, 8'($urandom), 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) step("wrap.last", 1, 8'($urandom), 1, 0, 0, 0);
      check_eq("wrap.count_const", op_count, 8'h00);

      // reset while an op is pending
      step("rst.a", 1, 8'h44, 0, 0, 0, 0);
      step("rst.b", 1, 8'h55, 0, 0, 0, 0);
      step("rst.op", 1, 8'h66, 0, 0, 0, 0);
      step("rst.hit", 0, 8'h00, 0, 0, 0, 1);
      check_eq("rst.op_valid_const", {7'd0, op_valid}, 8'h00);

`ifdef ALU_LOADER_KEEP_A_EN
      // chained op reusing operand A
      step("ka.a", 1, 8'h3C, 1, 0, 0, 0);
      step("ka.b", 1, 8'h10, 1, 0, 0, 0);
      step("ka.op", 1, 8'h01, 1, 0, 0, 0);
      step("ka.issue", 1, 8'hEE, 1, 0, 1, 0);
      step("ka.b2", 1, 8'h07, 0, 0, 0, 0);
      step("ka.op2", 1, 8'h02, 0, 0, 0, 0);
      check_eq("ka.a_const", a_out, 8'h3C);
      check_eq("ka.b_const", b_out, 8'h07);
      check_eq("ka.opc_const", {4'h0, opcode_out}, 8'h02);
      check_eq("ka.valid_const", {7'd0, op_valid}, 8'h01);
      step("ka.issue2", 0, 8'h00, 1, 0, 0, 0);
`endif

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         step("rand",
              1'($urandom_range(0, 3) != 0),
              8'($urandom),
              1'($urandom_range(0, 2) != 0),
              1'($urandom_range(0, 19) == 0),
              1'($urandom_range(0, 1)),
              1'($urandom_range(0, 99) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
